// File: rtl/hamming_pkg.sv
// hamming_pkg: shared widths, requester IDs and Hamming(7,4) syndrome helpers
package hamming_pkg;
  localparam int CW_W = 7;
  localparam int DATA_W = 4;
  localparam int SYN_W = 3;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
  // syndrome produced by a single error in each bit position, bit 6 first
  localparam logic [CW_W-1:0][SYN_W-1:0] H_COL = {3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b111, 3'b101};
  function automatic logic [SYN_W-1:0] syndrome(input logic [CW_W-1:0] c);
    return {c[6] ^ c[3] ^ c[1] ^ c[0], c[5] ^ c[3] ^ c[2] ^ c[1], c[4] ^ c[2] ^ c[1] ^ c[0]};
  endfunction
endpackage

// File: rtl/decod.sv
// decod: single-error-correcting Hamming(7,4) decoder returning the corrected payload
module decod
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0]   code,
  output logic [DATA_W-1:0] data
);
  logic [SYN_W-1:0] s;
  logic [DATA_W-1:0] flip;
  always_comb begin
    s = syndrome(code);
    for (int i = 0; i < DATA_W; i++) flip[i] = (s == H_COL[i]);
    data = code[DATA_W-1:0] ^ flip;
  end
endmodule

// File: rtl/hamming_dec_arbiter.sv
// hamming_dec_arbiter: round-robin front end sharing one Hamming(7,4) decoder between two requesters
module hamming_dec_arbiter
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [CW_W-1:0]   req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [CW_W-1:0]   req1_data,
  output logic              req1_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_id,
  output logic              out_corrected,
  output logic [CNT_W-1:0]  err_count,
  input  logic              err_count_clr
);
  logic last_grant, gnt, slot_free, acc;
  logic [CW_W-1:0] cw;
  logic [SYN_W-1:0] syn;
  logic [DATA_W-1:0] fixed;
  always_comb begin
    gnt = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    slot_free = ~out_valid | out_ready;
    // ready is held low during reset so nothing appears accepted while rst is high
    req0_ready = ~rst & slot_free & req0_valid & (gnt == REQ0);
    req1_ready = ~rst & slot_free & req1_valid & (gnt == REQ1);
    acc = req0_ready | req1_ready;
    cw = (gnt == REQ1) ? req1_data : req0_data;
    syn = syndrome(cw);
  end
  decod u_decod (.code(cw), .data(fixed));
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_id <= REQ0;
      out_corrected <= 1'b0;
      err_count <= '0;
      last_grant <= REQ1;
    end else begin
      if (acc) begin
        out_valid <= 1'b1;
        out_data <= fixed;
        out_id <= gnt;
        out_corrected <= |syn;
        last_grant <= gnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      err_count <= err_count_clr ? '0 : (acc & |syn & ~&err_count) ? err_count + CNT_W'(1) : err_count;
    end
  end
endmodule

// File: tb/tb_hamming_dec_arbiter.sv
// tb_hamming_dec_arbiter: random and directed stimulus against a nearest-codeword reference model
module tb_hamming_dec_arbiter;
  logic clk = 1'b0, rst, req0_valid, req1_valid, out_ready, err_count_clr;
  logic [6:0] req0_data, req1_data;
  logic req0_ready, req1_ready, out_valid, out_id, out_corrected;
  logic [3:0] out_data;
  logic [15:0] err_count;
  logic r0b, r1b, ovb, oidb, ocb;
  logic [3:0] odb;
  logic [1:0] err_count2;
  int n_checks = 0, n_fail = 0;
  bit m_valid = 0, m_id = 0, m_corr = 0, m_last = 1;
  logic [3:0] m_data = '0;
  int m_cnt = 0, m_cnt2 = 0;
  always #5 clk = ~clk;
  hamming_dec_arbiter dut (
    .clk(clk), .rst(rst), .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_id(out_id), .out_corrected(out_corrected),
    .err_count(err_count), .err_count_clr(err_count_clr)
  );
  hamming_dec_arbiter #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(r0b),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(r1b), .out_valid(ovb),
    .out_ready(out_ready), .out_data(odb), .out_id(oidb), .out_corrected(ocb),
    .err_count(err_count2), .err_count_clr(err_count_clr)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [6:0] enc(input logic [3:0] d);
    return {d[3] ^ d[1] ^ d[0], d[3] ^ d[2] ^ d[1], d[2] ^ d[1] ^ d[0], d};
  endfunction
  // the code is perfect, so every 7-bit word lies within distance 1 of exactly one codeword
  task automatic ref_decode(input logic [6:0] c, output logic [3:0] d, output bit corr);
    d = '0;
    corr = 0;
    for (int v = 0; v < 16; v++) if ($countones(enc(4'(v)) ^ c) <= 1) begin
      d = 4'(v);
      corr = enc(4'(v)) != c;
    end
  endtask
  task automatic cycle(input bit r, input bit v0, input logic [6:0] c0, input bit v1, input logic [6:0] c1,
                       input bit ordy, input bit clr);
    bit g, e0, e1, corr;
    logic [3:0] d;
    rst = r; req0_valid = v0; req0_data = c0; req1_valid = v1; req1_data = c1;
    out_ready = ordy; err_count_clr = clr;
    #1;
    g = (v0 && v1) ? !m_last : v1;
    e0 = !r && (!m_valid || ordy) && v0 && !g;
    e1 = !r && (!m_valid || ordy) && v1 && g;
    check("req0_ready", req0_ready, e0);
    check("req1_ready", req1_ready, e1);
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_data = 0; m_id = 0; m_corr = 0; m_cnt = 0; m_cnt2 = 0; m_last = 1;
    end else begin
      if (e0 || e1) begin
        ref_decode(g ? c1 : c0, d, corr);
        m_valid = 1; m_data = d; m_id = g; m_corr = corr; m_last = g;
        if (corr) begin
          m_cnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
          m_cnt2 = (m_cnt2 == 3) ? m_cnt2 : m_cnt2 + 1;
        end
      end else if (ordy) m_valid = 0;
      if (clr) begin
        m_cnt = 0;
        m_cnt2 = 0;
      end
    end
    #1;
    check("out_valid", out_valid, m_valid);
    check("out_data", out_data, m_data);
    check("out_id", out_id, m_id);
    check("out_corrected", out_corrected, m_corr);
    check("err_count", err_count, m_cnt);
    check("err_count_w2", err_count2, m_cnt2);
    check("out_data_w2", odb, m_data);
  endtask
  initial begin
    logic [6:0] x;
    cycle(1, 1, 7'h4B, 1, 7'h43, 1, 0);
    cycle(1, 1, 7'h4B, 1, 7'h43, 1, 0);
    cycle(0, 1, 7'h4B, 1, 7'h43, 1, 0);
    check("first_contest_id", out_id, 1'b0);
    cycle(0, 1, 7'h4B, 0, 7'h00, 1, 0);
    check("clean_data", out_data, 4'hB);
    cycle(0, 0, 7'h00, 1, 7'h43, 1, 0);
    check("single_err_data", out_data, 4'hB);
    check("single_err_corr", out_corrected, 1'b1);
    for (int b = 0; b < 7; b++) begin
      x = 7'h4B ^ (7'h01 << b);
      cycle(0, 0, 7'h00, 1, x, 1, 0);
      check("bitpos_data", out_data, 4'hB);
    end
    for (int k = 0; k < 8; k++) cycle(0, 1, enc(4'(k)), 1, enc(4'(k + 8)) ^ 7'h10, 1, 0);
    cycle(0, 1, 7'h4B, 1, 7'h43, 0, 0);
    for (int k = 0; k < 3; k++) cycle(0, 1, 7'h4B, 1, 7'h43, 0, 0);
    cycle(0, 1, 7'h4B, 1, 7'h43, 1, 0);
    cycle(1, 0, 7'h00, 0, 7'h00, 1, 0);
    for (int k = 0; k < 5; k++) cycle(0, 1, 7'h4B ^ 7'h08, 0, 7'h00, 1, 0);
    check("sat_w2", err_count2, 2'd3);
    cycle(0, 1, 7'h4B ^ 7'h01, 0, 7'h00, 1, 1);
    check("clr_priority", err_count, 16'd0);
    for (int k = 0; k < 400; k++) begin
      logic [6:0] a, b;
      a = $urandom_range(0, 3) == 0 ? 7'($urandom) : enc(4'($urandom)) ^ (7'h01 << $urandom_range(0, 7));
      b = $urandom_range(0, 3) == 0 ? 7'($urandom) : enc(4'($urandom)) ^ (7'h01 << $urandom_range(0, 7));
      cycle($urandom_range(0, 49) == 0, 1'($urandom), a, 1'($urandom), b,
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
